// File: rtl/pinmux_gpio_ctrl_pkg.sv
// pinmux_pkg: register map, FSM states and sizing helpers for pinmux_gpio_ctrl.
package pinmux_pkg;
    localparam logic [2:0] ADDR_DDR  = 3'd0;
    localparam logic [2:0] ADDR_PORT = 3'd1;
    localparam logic [2:0] ADDR_PIN  = 3'd2;
    localparam logic [2:0] ADDR_IEN  = 3'd3;
    localparam logic [2:0] ADDR_IFLG = 3'd4;

    typedef enum logic {ST_IDLE, ST_GUARD} state_t;

    function automatic int prof_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/pinmux_gpio_ctrl_if.sv
// pinmux_gpio_ctrl_if: GPIO register bus plus interrupt line.
interface pinmux_gpio_ctrl_if #(parameter int PORT_W = 8);
    logic              reg_we_i;
    logic              reg_re_i;
    logic [2:0]        reg_addr_i;
    logic [PORT_W-1:0] reg_wdata_i;
    logic [PORT_W-1:0] reg_rdata_o;
    logic              irq_o;

    modport master (output reg_we_i, reg_re_i, reg_addr_i, reg_wdata_i, input reg_rdata_o, irq_o);
    modport slave  (input reg_we_i, reg_re_i, reg_addr_i, reg_wdata_i, output reg_rdata_o, irq_o);
endinterface

// File: rtl/pinmux_gpio_ctrl_sync_edge.sv
// gpio_sync_edge: multi-stage input synchroniser with rising-edge detect.
module gpio_sync_edge #(
    parameter int W      = 8,
    parameter int STAGES = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_sync,
    output logic [W-1:0] o_rise
);
    logic [W-1:0] r_sync [STAGES];
    logic [W-1:0] r_prev;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync <= '{default: '0};
            r_prev <= '0;
        end else begin
            r_sync[0] <= i_d;
            for (int s = 1; s < STAGES; s++) r_sync[s] <= r_sync[s-1];
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_sync = r_sync[STAGES-1];
    assign o_rise = o_sync & ~r_prev;
endmodule

// File: rtl/pinmux_gpio_ctrl.sv
// pinmux_gpio_ctrl: runtime pad-profile mux with tristated guard on profile change
// and an overlaid DDR/PORT GPIO window with synchronised inputs and edge interrupts.
module pinmux_gpio_ctrl
    import pinmux_pkg::*;
#(
    parameter int NPADS       = 42,
    parameter int NPROFILES   = 4,
    parameter int PORT_W      = 8,
    parameter int PORT_BASE   = 30,
    parameter int GUARD_CYC   = 4,
    parameter int SYNC_STAGES = 2,
    localparam int PW = prof_w(NPROFILES)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [PW-1:0]              profile_sel_i,
    output logic                       profile_busy_o,
    input  logic [NPROFILES*NPADS-1:0] func_out_i,
    input  logic [NPROFILES*NPADS-1:0] func_oe_i,
    input  logic [PORT_W-1:0]          port_own_i,
    input  logic [NPADS-1:0]           io_in,
    output logic [NPADS-1:0]           io_out,
    output logic [NPADS-1:0]           io_oe,
    pinmux_gpio_ctrl_if.slave          bus
);
    localparam int CW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;

    state_t            r_state, w_next;
    logic [CW-1:0]     r_cnt, w_cnt_nxt;
    logic [PW-1:0]     r_target, w_target_nxt, r_active, w_active_nxt, w_sel, w_tgt;
    logic              r_fresh, w_guard;
    logic [NPADS-1:0]  r_io_out, r_io_oe, w_pad_out, w_pad_oe;
    logic [PORT_W-1:0] r_ddr, r_port, r_ien, r_iflg, r_rdata, w_rdata, w_sync, w_rise, w_pin;
    logic              r_irq, w_wr_ddr, w_wr_port, w_wr_ien, w_wr_iflg, w_unused;

    if ((1 << PW) > NPROFILES) begin : g_clamp
        assign w_sel = (int'(profile_sel_i) >= NPROFILES) ? PW'(NPROFILES - 1) : profile_sel_i;
    end else begin : g_noclamp
        assign w_sel = profile_sel_i;
    end

    // Out of reset the target tracks the request, so the first guard lands on it without a restart.
    assign w_tgt = r_fresh ? w_sel : r_target;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= ST_GUARD;
            r_cnt    <= CW'(GUARD_CYC - 1);
            r_target <= '0;
            r_active <= '0;
            r_fresh  <= 1'b1;
        end else begin
            r_state  <= w_next;
            r_cnt    <= w_cnt_nxt;
            r_target <= w_target_nxt;
            r_active <= w_active_nxt;
            r_fresh  <= 1'b0;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_cnt_nxt    = r_cnt;
        w_target_nxt = w_tgt;
        w_active_nxt = r_active;
        if (r_state == ST_IDLE) begin
            if (w_sel != r_active) begin
                w_next       = ST_GUARD;
                w_target_nxt = w_sel;
                w_cnt_nxt    = CW'(GUARD_CYC - 1);
            end
        end else if (w_sel != w_tgt) begin
            w_target_nxt = w_sel;
            w_cnt_nxt    = CW'(GUARD_CYC - 1);
        end else if (r_cnt == '0) begin
            w_active_nxt = w_tgt;
            w_next       = ST_IDLE;
        end else begin
            w_cnt_nxt = r_cnt - 1'b1;
        end
    end

    assign profile_busy_o = (r_state == ST_GUARD);
    // Blanking on the entry cycle too gives GUARD_CYC+1 tristated cycles.
    assign w_guard = (r_state == ST_GUARD) || (w_next == ST_GUARD);

    always_comb begin
        w_pad_out = func_out_i[int'(r_active)*NPADS +: NPADS];
        w_pad_oe  = func_oe_i[int'(r_active)*NPADS +: NPADS];
        for (int k = 0; k < PORT_W; k++) begin
            w_pad_out[PORT_BASE+k] = port_own_i[k] ? r_port[k] : w_pad_out[PORT_BASE+k];
            w_pad_oe[PORT_BASE+k]  = port_own_i[k] ? r_ddr[k]  : w_pad_oe[PORT_BASE+k];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_io_out <= '0;
            r_io_oe  <= '0;
        end else begin
            r_io_out <= w_guard ? '0 : w_pad_out;
            r_io_oe  <= w_guard ? '0 : w_pad_oe;
        end
    end

    assign io_out = r_io_out;
    assign io_oe  = r_io_oe;

    gpio_sync_edge #(.W(PORT_W), .STAGES(SYNC_STAGES)) u_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .i_d    (io_in[PORT_BASE +: PORT_W]),
        .o_sync (w_sync),
        .o_rise (w_rise)
    );

    assign w_unused  = ^io_in;
    assign w_pin     = (r_ddr & r_port) | (~r_ddr & w_sync);
    assign w_wr_ddr  = bus.reg_we_i && (bus.reg_addr_i == ADDR_DDR);
    assign w_wr_port = bus.reg_we_i && (bus.reg_addr_i == ADDR_PORT);
    assign w_wr_ien  = bus.reg_we_i && (bus.reg_addr_i == ADDR_IEN);
    assign w_wr_iflg = bus.reg_we_i && (bus.reg_addr_i == ADDR_IFLG);

    always_comb begin
        w_rdata = (bus.reg_addr_i == ADDR_DDR)  ? r_ddr  :
                  (bus.reg_addr_i == ADDR_PORT) ? r_port :
                  (bus.reg_addr_i == ADDR_PIN)  ? w_pin  :
                  (bus.reg_addr_i == ADDR_IEN)  ? r_ien  :
                  (bus.reg_addr_i == ADDR_IFLG) ? r_iflg : '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ddr   <= '0;
            r_port  <= '0;
            r_ien   <= '0;
            r_iflg  <= '0;
            r_irq   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ddr   <= w_wr_ddr  ? bus.reg_wdata_i : r_ddr;
            r_port  <= w_wr_port ? bus.reg_wdata_i : r_port;
            r_ien   <= w_wr_ien  ? bus.reg_wdata_i : r_ien;
            r_iflg  <= (r_iflg & ~(w_wr_iflg ? bus.reg_wdata_i : '0)) | (w_rise & ~r_ddr & port_own_i);
            r_irq   <= |(r_iflg & r_ien);
            r_rdata <= bus.reg_re_i ? w_rdata : r_rdata;
        end
    end

    assign bus.reg_rdata_o = r_rdata;
    assign bus.irq_o       = r_irq;
endmodule

// File: tb/tb_pinmux_gpio_ctrl.sv
// tb_pinmux_gpio_ctrl: vector table for pad mapping, scoreboarded register reads,
// and hand sequences for guard timing, edge interrupts and reset.
module tb_pinmux_gpio_ctrl;
    localparam int NPADS = 42, NPROF = 4, PW = 8, BASE = 30, GC = 4, SS = 2, NV = 6;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [1:0]             sel;
    logic                   busy;
    logic [NPROF*NPADS-1:0] fout, foe;
    logic [PW-1:0]          own;
    logic [NPADS-1:0]       io_in, io_out, io_oe;

    pinmux_gpio_ctrl_if #(.PORT_W(PW)) bus ();

    pinmux_gpio_ctrl #(
        .NPADS(NPADS), .NPROFILES(NPROF), .PORT_W(PW), .PORT_BASE(BASE),
        .GUARD_CYC(GC), .SYNC_STAGES(SS)
    ) dut (
        .clk_i(clk), .rst_i(rst), .profile_sel_i(sel), .profile_busy_o(busy),
        .func_out_i(fout), .func_oe_i(foe), .port_own_i(own),
        .io_in(io_in), .io_out(io_out), .io_oe(io_oe), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       sel;
        logic [7:0]       own, ddr, port;
        logic [NPADS-1:0] eo, ee;
    } vec_t;
    typedef struct {
        string      name;
        logic [7:0] exp;
    } sb_t;

    localparam logic [31:0] TV [NV] = '{
        {8'd1, 8'h00, 8'h00, 8'h00}, {8'd3, 8'hFF, 8'h0F, 8'hA5}, {8'd2, 8'h0F, 8'hFF, 8'h3C},
        {8'd2, 8'hF0, 8'h55, 8'h0F}, {8'd0, 8'h81, 8'h80, 8'h81}, {8'd3, 8'h3C, 8'hC3, 8'h5A}};

    int               n_tests = 0, n_fail = 0;
    logic [NPADS-1:0] pf_out [NPROF], pf_oe [NPROF];
    vec_t             vecs [NV];
    sb_t              sb_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model(input int p, input logic [7:0] o, d, pt,
                                  output logic [NPADS-1:0] mo, me);
        mo = pf_out[p];
        me = pf_oe[p];
        for (int k = 0; k < PW; k++) if (o[k]) begin
            mo[BASE+k] = pt[k];
            me[BASE+k] = d[k];
        end
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        bus.reg_we_i = 1'b1; bus.reg_addr_i = a; bus.reg_wdata_i = d;
        @(negedge clk);
        bus.reg_we_i = 1'b0;
    endtask

    task automatic pop_chk();
        sb_t s;
        if (sb_q.size() == 0) begin
            chk("sb_underflow", 64'd0, 64'd1);
        end else begin
            s = sb_q.pop_front();
            chk(s.name, 64'(bus.reg_rdata_o), 64'(s.exp));
        end
    endtask

    task automatic rd(input logic [2:0] a, input logic [7:0] e, input string name);
        sb_q.push_back('{name: name, exp: e});
        bus.reg_re_i = 1'b1; bus.reg_addr_i = a;
        @(negedge clk);
        bus.reg_re_i = 1'b0;
        pop_chk();
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while (busy && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk(name, 64'(busy), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] t;
        int          c;
        logic        nz;
        for (int p = 0; p < NPROF; p++) begin
            t = {$urandom(), $urandom()};
            pf_out[p] = t[NPADS-1:0];
            t = {$urandom(), $urandom()};
            pf_oe[p] = t[NPADS-1:0];
            pf_oe[p][2:0] = {2'(p), 1'b1};
            fout[p*NPADS +: NPADS] = pf_out[p];
            foe[p*NPADS +: NPADS]  = pf_oe[p];
        end
        for (int i = 0; i < NV; i++) begin
            vecs[i].sel  = TV[i][25:24];
            vecs[i].own  = TV[i][23:16];
            vecs[i].ddr  = TV[i][15:8];
            vecs[i].port = TV[i][7:0];
            model(int'(vecs[i].sel), vecs[i].own, vecs[i].ddr, vecs[i].port, vecs[i].eo, vecs[i].ee);
        end
        sel = 2'd2; own = '0; io_in = '0;
        bus.reg_we_i = 1'b0; bus.reg_re_i = 1'b0; bus.reg_addr_i = '0; bus.reg_wdata_i = '0;

        // Reset state and first guard interval into profile 2
        cyc(2);
        chk("rst_oe", 64'(io_oe), 64'd0);
        chk("rst_out", 64'(io_out), 64'd0);
        chk("rst_busy", 64'(busy), 64'd1);
        chk("rst_irq", 64'(bus.irq_o), 64'd0);
        chk("rst_rdata", 64'(bus.reg_rdata_o), 64'd0);
        rst = 1'b0;
        c = 0; nz = 1'b0;
        while (c < 20) begin
            @(negedge clk);
            c++;
            if (c == 1) chk("busy_after_rst", 64'(busy), 64'd1);
            if (io_oe == pf_oe[2]) break;
            if (io_oe != '0 || io_out != '0) nz = 1'b1;
        end
        chk("rst_guard_len", 64'(c), 64'(GC + 1));
        chk("rst_guard_tristate", 64'(nz), 64'd0);
        chk("prof2_out", 64'(io_out), 64'(pf_out[2]));
        chk("prof2_busy", 64'(busy), 64'd0);

        // Guard restart: 1 -> 3 -> 0 two cycles apart
        sel = 2'd1;
        cyc(1); wait_idle("idle_p1"); cyc(2);
        chk("prof1_oe", 64'(io_oe), 64'(pf_oe[1]));
        sel = 2'd3;
        cyc(1);
        chk("guard_enter_oe", 64'(io_oe), 64'd0);
        cyc(1);
        sel = 2'd0;
        cyc(1);
        c = 0; nz = 1'b0;
        while (c < 20) begin
            @(negedge clk);
            c++;
            if (io_oe == pf_oe[0]) break;
            if (io_oe != '0 || io_out != '0) nz = 1'b1;
        end
        chk("restart_len", 64'(c), 64'(GC + 1));
        chk("restart_no_p3", 64'(nz), 64'd0);
        chk("prof0_out", 64'(io_out), 64'(pf_out[0]));

        // Table-driven pad mapping
        for (int i = 0; i < NV; i++) begin
            wr(3'd0, vecs[i].ddr);
            wr(3'd1, vecs[i].port);
            own = vecs[i].own; sel = vecs[i].sel;
            cyc(1); wait_idle($sformatf("vec%0d_idle", i)); cyc(2);
            chk($sformatf("vec%0d_out", i), 64'(io_out), 64'(vecs[i].eo));
            chk($sformatf("vec%0d_oe", i), 64'(io_oe), 64'(vecs[i].ee));
        end

        // GPIO window drive and PIN readback
        own = 8'hFF;
        wr(3'd0, 8'h0F); wr(3'd1, 8'hA5);
        cyc(2);
        chk("win_out", 64'(io_out[33:30]), 64'h5);
        chk("win_oe", 64'(io_oe[37:30]), 64'h0F);
        io_in[37:34] = 4'b1100;
        cyc(SS + 1);
        rd(3'd2, 8'hC5, "pin_c5");
        rd(3'd4, 8'hC0, "iflg_inputs_rise");
        wr(3'd4, 8'hFF);
        rd(3'd4, 8'h00, "iflg_w1c_all");

        // Edge interrupt latency, W1C, and set-wins-over-clear
        wr(3'd3, 8'h10);
        io_in[34] = 1'b1;
        cyc(SS + 1);
        chk("irq_early", 64'(bus.irq_o), 64'd0);
        cyc(1);
        chk("irq_set", 64'(bus.irq_o), 64'd1);
        rd(3'd4, 8'h10, "iflg_bit4");
        wr(3'd4, 8'h10);
        cyc(1);
        chk("irq_cleared", 64'(bus.irq_o), 64'd0);
        rd(3'd4, 8'h00, "iflg_cleared");
        io_in[34] = 1'b0; cyc(SS + 2);
        io_in[34] = 1'b1; cyc(SS + 2);
        chk("irq_again", 64'(bus.irq_o), 64'd1);
        io_in[34] = 1'b0; cyc(SS + 2);
        io_in[34] = 1'b1; cyc(2);
        wr(3'd4, 8'h10);
        rd(3'd4, 8'h10, "set_wins_w1c");

        // Masked edges, DDR write keeps flags, unmapped addresses
        wr(3'd4, 8'hFF);
        wr(3'd0, 8'h01);
        io_in[30] = 1'b1; cyc(SS + 2);
        rd(3'd4, 8'h00, "ddr_masks_edge");
        io_in[30] = 1'b0; cyc(SS + 2);
        wr(3'd0, 8'h00);
        own = 8'hFE;
        io_in[30] = 1'b1; cyc(SS + 2);
        rd(3'd4, 8'h00, "own_masks_edge");
        own = 8'hFF;
        io_in[30] = 1'b0; cyc(SS + 2);
        io_in[30] = 1'b1; cyc(SS + 2);
        rd(3'd4, 8'h01, "bit0_edge");
        wr(3'd0, 8'h0F);
        rd(3'd4, 8'h01, "ddr_wr_keeps_flag");
        for (int a = 5; a < 8; a++) wr(3'(a), 8'hFF);
        rd(3'd0, 8'h0F, "ddr_after_bad_wr");
        rd(3'd1, 8'hA5, "port_after_bad_wr");
        rd(3'd3, 8'h10, "ien_after_bad_wr");
        rd(3'd4, 8'h01, "iflg_after_bad_wr");
        for (int a = 5; a < 8; a++) rd(3'(a), 8'h00, $sformatf("addr%0d_reads0", a));

        // Same-cycle write and read return the old value
        sb_q.push_back('{name: "rw_same_old", exp: 8'h0F});
        bus.reg_we_i = 1'b1; bus.reg_re_i = 1'b1; bus.reg_addr_i = 3'd0; bus.reg_wdata_i = 8'h33;
        @(negedge clk);
        bus.reg_we_i = 1'b0; bus.reg_re_i = 1'b0;
        pop_chk();
        rd(3'd0, 8'h33, "rw_same_new");
        rd(3'd2, 8'hE1, "pin_mixed");

        // Asynchronous reset mid-guard with a pending interrupt
        wr(3'd3, 8'h01);
        cyc(1);
        chk("irq_pre_rst", 64'(bus.irq_o), 64'd1);
        rd(3'd0, 8'h33, "rdata_pre_rst");
        sel = 2'd1;
        cyc(2);
        chk("busy_pre_rst", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_irq", 64'(bus.irq_o), 64'd0);
        chk("arst_rdata", 64'(bus.reg_rdata_o), 64'd0);
        chk("arst_oe", 64'(io_oe), 64'd0);
        chk("arst_out", 64'(io_out), 64'd0);
        chk("arst_busy", 64'(busy), 64'd1);
        own = '0; io_in = '0;
        @(negedge clk);
        rst = 1'b0;
        rd(3'd0, 8'h00, "post_rst_ddr");
        rd(3'd1, 8'h00, "post_rst_port");
        rd(3'd3, 8'h00, "post_rst_ien");
        rd(3'd4, 8'h00, "post_rst_iflg");
        wait_idle("post_rst_idle"); cyc(2);
        chk("post_rst_prof1", 64'(io_oe), 64'(pf_oe[1]));
        chk("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
